ldm_scan_ctrl: RTL and testbench
================================

// Module: ldm_scan_ctrl
// PURPOSE
// - Parametrised local-dimming scan controller. Generalises the fixed 16x16 fsm+p2s pair.
// - Captures one full backlight frame (ROWS x COLS bits) into a pending buffer,
//   then copies it to an active buffer.
// - Scans the active buffer row by row onto the LDM panel bus with a programmable strobe clock.
// - Double buffering lets the next frame be loaded while the current one is being scanned.
// PARAMETERS
// - ROWS      16  number of LDM lines (zones vertically), >=2
// - COLS      16  bits per line (ldm_line_data width), >=1
// - AW        4   address width, must satisfy 2**AW >= ROWS
// - CLK_DIV   2   clk cycles per scan phase, >=1
// - CONT      1   1 = rescan the active frame continuously; 0 = scan once, then idle
// PORTS
// - clk              in   1          system clock, all logic on rising edge
// - rst              in   1          asynchronous reset, active-high
// - pixel_data       in   ROWS*COLS  frame; row r = pixel_data[r*COLS +: COLS]
// - pixel_data_en    in   1          1-cycle load strobe for pixel_data
// - ldm_clk          out  1          panel strobe clock
// - ldm_addr_en      out  1          line address valid
// - ldm_addr         out  AW         current line index
// - ldm_line_data    out  COLS       current line bits
// - frame_start      out  1          1-cycle pulse when row 0 of a frame begins
// - busy             out  1          1 while not in IDLE
// - ovf              out  1          1-cycle pulse: a pending frame was overwritten before use
// BEHAVIOUR
// - Reset (asynchronous, any time, including mid-frame):
//   - all outputs 0, FSM=IDLE, both buffers and pend_vld cleared.
//   - The first clk edge after rst deasserts is an ordinary cycle.
// - Load: pixel_data_en=1 writes pixel_data into pend_buf and sets pend_vld=1 on that edge.
//   - If pend_vld was already 1 and is not being consumed on the same edge, ovf pulses 1 cycle.
// - Consume: at a frame boundary (IDLE, or after last row's HOLD) with pend_vld=1:
//   - pend_buf is copied to act_buf, row=0, frame_start pulses.
//   - pend_vld clears unless pixel_data_en is 1 on the same edge. In that case the new data
//     lands in pend_buf, pend_vld stays 1, and no ovf is raised.
// - Frame boundary with pend_vld=0:
//   - CONT=1 and act_buf has been loaded at least once: rescan act_buf from row 0
//     (frame_start pulses).
//   - Otherwise: go to IDLE.
// - FSM states: IDLE -> SETUP -> STROBE -> HOLD -> (SETUP of row+1 | frame boundary).
//   Each of SETUP, STROBE and HOLD lasts exactly CLK_DIV cycles (divider counter).
//   - SETUP: ldm_addr_en=1, ldm_clk=0, ldm_addr=row, ldm_line_data=act_buf row.
//   - STROBE: ldm_addr_en=1, ldm_clk=1; addr and data stable.
//   - HOLD: ldm_addr_en=0, ldm_clk=0; addr and data hold their last value.
//   - IDLE: ldm_clk=0, ldm_addr_en=0, addr and data 0.
// - Timing:
//   - Line period = 3*CLK_DIV cycles; frame period = ROWS*3*CLK_DIV cycles.
//   - No gap between frames in CONT mode.
//   - Latency: a load strobe in IDLE reaches the first SETUP output 1 cycle after the strobe edge.
// - Row wrap: row counts 0..ROWS-1 then returns to 0; ldm_addr never exceeds ROWS-1.
// - act_buf never changes mid-frame; a load during a scan only affects pend_buf.
// CONFIGURATION
// - LDM_PARITY_EN defined:
//   - adds output ldm_line_par (1 bit) = ^ldm_line_data (even parity), timed with ldm_line_data.
//   - ldm_line_par is 0 in IDLE and reset.
// - LDM_PARITY_EN undefined: port and logic absent; all other behaviour is identical.
// TESTING
// - Defaults. Load row r = 16'h0101*r, one strobe ->
//   16 lines, ldm_addr 0..15, ldm_line_data matches each row, 6 cycles/line, frame_start once.
// - CONT=0, single load -> busy low exactly 96 cycles after the first SETUP; outputs return to 0.
// - Two strobes 10 cycles apart mid-frame -> ovf pulse on the second strobe;
//   the next frame shows the second data.
// - Strobe on the exact cycle of the frame-boundary consume -> old pending becomes active,
//   new data stays pending, ovf=0.
// - Assert rst in the STROBE phase of row 7 -> ldm_clk, ldm_addr_en, busy = 0 immediately,
//   without waiting for a clk edge; no scan until a new strobe.
// - LDM_PARITY_EN, row data 16'h0007 -> ldm_line_par=1; data 16'h0003 -> 0.

Source files
------------

// File: rtl/ldm_scan_ctrl.sv
// ldm_scan_ctrl: parametrised local-dimming backlight scan controller.
//
// A full frame (ROWS x COLS bits) is captured into a pending buffer on a one-cycle load
// strobe. At each frame boundary the pending frame (if any) is promoted to the active buffer.
// The active buffer is then scanned line by line onto the panel bus. Each line goes through
// three phases (SETUP, STROBE, HOLD), and each phase lasts CLK_DIV clocks. Because the frame
// is double buffered, the next frame can be loaded while the current one is being scanned.
//
// Optional feature (compile-time macro):
//   LDM_PARITY_EN  adds ldm_line_par, the even parity of ldm_line_data.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous reset, active-high
//   pixel_data     in   frame; row r = pixel_data[r*COLS +: COLS]
//   pixel_data_en  in   one-cycle load strobe for pixel_data
//   ldm_clk        out  panel strobe clock (high during STROBE)
//   ldm_addr_en    out  line address valid (SETUP and STROBE)
//   ldm_addr       out  current line index
//   ldm_line_data  out  current line bits
//   frame_start    out  one-cycle pulse in the first cycle of row 0
//   busy           out  high whenever the scanner is not idle
//   ldm_line_par   out  (LDM_PARITY_EN only) ^ldm_line_data
//   ovf            out  one-cycle pulse when an unconsumed pending frame is overwritten
module ldm_scan_ctrl #(
  parameter int unsigned ROWS    = 16,
  parameter int unsigned COLS    = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CONT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] pixel_data,
  input  logic                 pixel_data_en,
  output logic                 ldm_clk,
  output logic                 ldm_addr_en,
  output logic [AW-1:0]        ldm_addr,
  output logic [COLS-1:0]      ldm_line_data,
  output logic                 frame_start,
  output logic                 busy,
`ifdef LDM_PARITY_EN
  output logic                 ldm_line_par,
`endif
  output logic                 ovf
);

  localparam int unsigned   DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);
  localparam logic [AW-1:0] RowLast = AW'(ROWS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } state_e;

  state_e                 state_q, state_d;
  logic [DW-1:0]          div_q, div_d;
  logic [AW-1:0]          row_q, row_d;
  logic [ROWS*COLS-1:0]   pend_buf_q;
  logic [ROWS*COLS-1:0]   act_buf_q;
  logic                   pend_vld_q, pend_vld_d;
  logic                   act_loaded_q, act_loaded_d;
  logic                   frame_start_q, frame_start_d;
  logic                   ovf_q, ovf_d;
  logic                   ldm_clk_q, ldm_clk_d;
  logic                   addr_en_q, addr_en_d;
  logic                   phase_done;
  logic                   consume;
  logic                   restart;
  logic [COLS-1:0]        row_bits;

  // State, counters and buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      div_q         <= '0;
      row_q         <= '0;
      pend_buf_q    <= '0;
      act_buf_q     <= '0;
      pend_vld_q    <= 1'b0;
      act_loaded_q  <= 1'b0;
      frame_start_q <= 1'b0;
      ovf_q         <= 1'b0;
      ldm_clk_q     <= 1'b0;
      addr_en_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      row_q         <= row_d;
      pend_vld_q    <= pend_vld_d;
      act_loaded_q  <= act_loaded_d;
      frame_start_q <= frame_start_d;
      ovf_q         <= ovf_d;
      ldm_clk_q     <= ldm_clk_d;
      addr_en_q     <= addr_en_d;
      if (pixel_data_en) begin
        pend_buf_q <= pixel_data;
      end
      // Reads the old pending frame, so a load on the same edge stays pending.
      if (consume) begin
        act_buf_q <= pend_buf_q;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    row_d         = row_q;
    pend_vld_d    = pend_vld_q;
    act_loaded_d  = act_loaded_q;
    frame_start_d = 1'b0;
    ovf_d         = 1'b0;
    consume       = 1'b0;
    restart       = 1'b0;
    phase_done    = (div_q == DivLast);

    unique case (state_q)
      StIdle: begin
        consume = pend_vld_q;
      end
      StSetup: begin
        if (phase_done) begin
          state_d = StStrobe;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      StStrobe: begin
        if (phase_done) begin
          state_d = StHold;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      StHold: begin
        if (phase_done) begin
          div_d = '0;
          if (row_q != RowLast) begin
            row_d   = row_q + AW'(1);
            state_d = StSetup;
          end else if (pend_vld_q) begin
            consume = 1'b1;
          end else if ((CONT != 0) && act_loaded_q) begin
            restart = 1'b1;
          end else begin
            state_d = StIdle;
            row_d   = '0;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Frame boundary: start at row 0, either with a new frame or a rescan of the active one.
    if (consume || restart) begin
      state_d       = StSetup;
      row_d         = '0;
      div_d         = '0;
      frame_start_d = 1'b1;
    end
    if (consume) begin
      pend_vld_d   = 1'b0;
      act_loaded_d = 1'b1;
    end
    // A load on the consume edge refills the pending slot without counting as overflow.
    if (pixel_data_en) begin
      pend_vld_d = 1'b1;
      ovf_d      = pend_vld_q && !consume;
    end

    // Registered panel strobes so ldm_clk is glitch-free.
    ldm_clk_d = (state_d == StStrobe);
    addr_en_d = (state_d == StSetup) || (state_d == StStrobe);
  end

  assign row_bits      = act_buf_q[32'(row_q) * COLS +: COLS];
  assign busy          = (state_q != StIdle);
  assign ldm_clk       = ldm_clk_q;
  assign ldm_addr_en   = addr_en_q;
  assign ldm_addr      = busy ? row_q : '0;
  assign ldm_line_data = busy ? row_bits : '0;
  assign frame_start   = frame_start_q;
  assign ovf           = ovf_q;

`ifdef LDM_PARITY_EN
  assign ldm_line_par  = ^ldm_line_data;
`endif

endmodule

// File: tb/tb_ldm_scan_ctrl.sv
// Testbench for ldm_scan_ctrl.
// It drives two instances from the same stimulus: one with CONT=1 and one with CONT=0.
// Both instances are compared every cycle against a behavioural model of the scan position.
// There are also table-driven and directed checks for the corner cases.
module tb_ldm_scan_ctrl;

  localparam int ROWS    = 16;
  localparam int COLS    = 16;
  localparam int AW      = 4;
  localparam int CLK_DIV = 2;
  localparam int LINE    = 3 * CLK_DIV;
  localparam int FRAME   = ROWS * LINE;
  localparam int FW      = ROWS * COLS;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [FW-1:0]         pixel_data;
  logic                  pixel_data_en;
  logic [1:0]            lclk_w, aen_w, fs_w, busy_w, ovf_w;
  logic [1:0][AW-1:0]    addr_w;
  logic [1:0][COLS-1:0]  data_w;
`ifdef LDM_PARITY_EN
  logic [1:0]            par_w;
`endif

  always #5 clk = ~clk;

  ldm_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .AW(AW), .CLK_DIV(CLK_DIV), .CONT(1)
  ) u_dut (
    .clk(clk), .rst(rst), .pixel_data(pixel_data), .pixel_data_en(pixel_data_en),
    .ldm_clk(lclk_w[0]), .ldm_addr_en(aen_w[0]), .ldm_addr(addr_w[0]),
    .ldm_line_data(data_w[0]), .frame_start(fs_w[0]), .busy(busy_w[0]),
`ifdef LDM_PARITY_EN
    .ldm_line_par(par_w[0]),
`endif
    .ovf(ovf_w[0])
  );

  ldm_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .AW(AW), .CLK_DIV(CLK_DIV), .CONT(0)
  ) u_dut1 (
    .clk(clk), .rst(rst), .pixel_data(pixel_data), .pixel_data_en(pixel_data_en),
    .ldm_clk(lclk_w[1]), .ldm_addr_en(aen_w[1]), .ldm_addr(addr_w[1]),
    .ldm_line_data(data_w[1]), .frame_start(fs_w[1]), .busy(busy_w[1]),
`ifdef LDM_PARITY_EN
    .ldm_line_par(par_w[1]),
`endif
    .ovf(ovf_w[1])
  );

  // Reference model: m_pos is the cycle index within the frame, or -1 when idle.
  logic [FW-1:0] m_act [2];
  logic [FW-1:0] m_pend [2];
  bit            m_pvld [2];
  bit            m_loaded [2];
  bit            m_fs [2];
  bit            m_ovf [2];
  int            m_pos [2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = '0; m_pend[i] = '0; m_pvld[i] = 0; m_loaded[i] = 0;
      m_fs[i] = 0; m_ovf[i] = 0; m_pos[i] = -1;
    end
  endtask

  task automatic model_step(input int i, input bit cont, input bit en, input logic [FW-1:0] d);
    bit boundary, consume;
    boundary  = (m_pos[i] < 0) || (m_pos[i] == FRAME - 1);
    consume   = boundary && m_pvld[i];
    m_ovf[i]  = en && m_pvld[i] && !consume;
    m_fs[i]   = 0;
    if (boundary) begin
      if (consume) begin
        m_act[i] = m_pend[i]; m_loaded[i] = 1; m_pvld[i] = 0; m_pos[i] = 0; m_fs[i] = 1;
      end else if (cont && m_loaded[i] && m_pos[i] >= 0) begin
        m_pos[i] = 0; m_fs[i] = 1;
      end else begin
        m_pos[i] = -1;
      end
    end else begin
      m_pos[i]++;
    end
    if (en) begin
      m_pend[i] = d; m_pvld[i] = 1;
    end
  endtask

  task automatic model_compare(input int i);
    int line, ph;
    logic [COLS-1:0] ed;
    logic eclk, eaen, ebusy;
    if (m_pos[i] < 0) begin
      line = 0; ed = '0; eclk = 0; eaen = 0; ebusy = 0;
    end else begin
      line  = m_pos[i] / LINE;
      ph    = (m_pos[i] % LINE) / CLK_DIV;
      ed    = m_act[i][line*COLS +: COLS];
      eclk  = (ph == 1);
      eaen  = (ph < 2);
      ebusy = 1;
    end
    check($sformatf("c%0d.addr", i), addr_w[i], line);
    check($sformatf("c%0d.data", i), data_w[i], ed);
    check($sformatf("c%0d.ldm_clk", i), lclk_w[i], eclk);
    check($sformatf("c%0d.addr_en", i), aen_w[i], eaen);
    check($sformatf("c%0d.busy", i), busy_w[i], ebusy);
    check($sformatf("c%0d.frame_start", i), fs_w[i], m_fs[i]);
    check($sformatf("c%0d.ovf", i), ovf_w[i], m_ovf[i]);
`ifdef LDM_PARITY_EN
    check($sformatf("c%0d.par", i), par_w[i], ^ed);
`endif
  endtask

  // One clock: drive inputs, advance models on the edge, compare 1 time unit later.
  task automatic step(input bit en, input logic [FW-1:0] d);
    pixel_data_en = en;
    pixel_data    = d;
    @(posedge clk);
    model_step(0, 1'b1, en, d);
    model_step(1, 1'b0, en, d);
    #1;
    model_compare(0);
    model_compare(1);
    pixel_data_en = 1'b0;
  endtask

  function automatic logic [FW-1:0] pat_frame(input logic [15:0] base, input logic [15:0] mul);
    logic [FW-1:0] f;
    logic [15:0]   rr;
    f = '0;
    for (int r = 0; r < ROWS; r++) begin
      rr = 16'(r);
      f[r*COLS +: COLS] = base + rr * mul;
    end
    return f;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int w = 0; w < FW / 32; w++) f[w*32 +: 32] = $urandom();
    return f;
  endfunction

  typedef struct {
    int              cyc;
    logic [AW-1:0]   addr;
    logic [COLS-1:0] data;
    logic            lclk;
    logic            aen;
    logic            fs;
    logic            busy1;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int  k;
    bit  found;
    logic [FW-1:0] f;

    // Cycles are counted after the load strobe edge; row r carries 16'h0101*r.
    tbl[0]  = '{1,   4'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{2,   4'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{3,   4'd0,  16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{5,   4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{7,   4'd1,  16'h0101, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{9,   4'd1,  16'h0101, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{46,  4'd7,  16'h0707, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{91,  4'd15, 16'h0F0F, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{96,  4'd15, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{97,  4'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{103, 4'd1,  16'h0101, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; pixel_data = '0; pixel_data_en = 1'b0;
    model_reset();
    #12;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset.c%0d.ldm_clk", i), lclk_w[i], 0);
      check($sformatf("reset.c%0d.addr_en", i), aen_w[i], 0);
      check($sformatf("reset.c%0d.addr", i), addr_w[i], 0);
      check($sformatf("reset.c%0d.data", i), data_w[i], 0);
      check($sformatf("reset.c%0d.busy", i), busy_w[i], 0);
      check($sformatf("reset.c%0d.fs", i), fs_w[i], 0);
      check($sformatf("reset.c%0d.ovf", i), ovf_w[i], 0);
    end
    @(posedge clk); #3; rst = 1'b0;
    repeat (3) step(1'b0, '0);

    // First frame, table driven.
    step(1'b1, pat_frame(16'h0000, 16'h0101));
    k = 0;
    for (int t = 0; t < 11; t++) begin
      while (k < tbl[t].cyc) begin
        step(1'b0, '0);
        k++;
      end
      check($sformatf("tbl%0d.addr", t), addr_w[0], tbl[t].addr);
      check($sformatf("tbl%0d.data", t), data_w[0], tbl[t].data);
      check($sformatf("tbl%0d.ldm_clk", t), lclk_w[0], tbl[t].lclk);
      check($sformatf("tbl%0d.addr_en", t), aen_w[0], tbl[t].aen);
      check($sformatf("tbl%0d.fs", t), fs_w[0], tbl[t].fs);
      check($sformatf("tbl%0d.busy_once", t), busy_w[1], tbl[t].busy1);
`ifdef LDM_PARITY_EN
      check($sformatf("tbl%0d.par", t), par_w[0], ^tbl[t].data);
`endif
    end

    // Two strobes 10 cycles apart mid-frame: the second overwrites the first.
    step(1'b1, pat_frame(16'hB000, 16'h0001));
    check("ovf.first_strobe", ovf_w[0], 0);
    repeat (9) step(1'b0, '0);
    step(1'b1, pat_frame(16'hC000, 16'h0001));
    check("ovf.second_strobe", ovf_w[0], 1);
    step(1'b0, '0);
    check("ovf.pulse_width", ovf_w[0], 0);
    found = 0;
    for (int n = 0; n < 2 * FRAME && !found; n++) begin
      step(1'b0, '0);
      if (fs_w[0]) found = 1;
    end
    check("ovf.wait_frame", found, 1);
    check("ovf.next_row0", data_w[0], 16'hC000);
    repeat (LINE) step(1'b0, '0);
    check("ovf.next_row1", data_w[0], 16'hC001);

    // Strobe exactly on the consume edge.
    step(1'b1, pat_frame(16'hD000, 16'h0001));
    found = 0;
    for (int n = 0; n < 2 * FRAME && !found; n++) begin
      if (m_pos[0] == FRAME - 1) found = 1;
      else step(1'b0, '0);
    end
    check("edge.wait_boundary", found, 1);
    step(1'b1, pat_frame(16'hE000, 16'h0001));
    check("edge.frame_start", fs_w[0], 1);
    check("edge.active_old", data_w[0], 16'hD000);
    check("edge.no_ovf", ovf_w[0], 0);
    found = 0;
    for (int n = 0; n < 2 * FRAME && !found; n++) begin
      step(1'b0, '0);
      if (fs_w[0]) found = 1;
    end
    check("edge.wait_next", found, 1);
    check("edge.pending_new", data_w[0], 16'hE000);

    // Asynchronous reset during the STROBE phase of row 7.
    found = 0;
    for (int n = 0; n < 2 * FRAME && !found; n++) begin
      if (m_pos[0] == 7 * LINE + CLK_DIV) found = 1;
      else step(1'b0, '0);
    end
    check("rst.wait_row7", found, 1);
    check("rst.pre_ldm_clk", lclk_w[0], 1);
    #2; rst = 1'b1; #1;
    check("rst.ldm_clk", lclk_w[0], 0);
    check("rst.addr_en", aen_w[0], 0);
    check("rst.busy", busy_w[0], 0);
    check("rst.busy_once", busy_w[1], 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3; rst = 1'b0;
    repeat (20) step(1'b0, '0);
    check("rst.no_scan", busy_w[0], 0);

`ifdef LDM_PARITY_EN
    f = '0;
    f[15:0]  = 16'h0007;
    f[31:16] = 16'h0003;
    step(1'b1, f);
    step(1'b0, '0);
    check("par.row0_odd", par_w[0], 1);
    repeat (LINE) step(1'b0, '0);
    check("par.row1_even", par_w[0], 0);
`endif

    // Randomised loads against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        f = rand_frame();
        step(1'b1, f);
      end else begin
        step(1'b0, '0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
